// File: rtl/mtc_gnt_serializer.sv
// mtc_gnt_serializer
// Takes a multi-hot grant vector from the arbiter and replays it as a stream
// of single grants, lowest bit first, one per output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid high keeps
// its payload stable until that transfer. gnt_rdy_o depends combinationally
// on out_rdy_i, so a new vector can be taken on the same edge that the last
// grant of the current vector leaves, which gives back-to-back vectors with
// no idle cycle in between.
module mtc_gnt_serializer #(
    parameter  int WIDTH_N  = 8,
    parameter  int AMOUNT_M = 3,
    localparam int IDX_W    = $clog2(WIDTH_N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH_N-1:0] gnt_i,
    input  logic               gnt_vld_i,
    output logic               gnt_rdy_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [WIDTH_N-1:0] onehot_o,
    output logic               last_o,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic               err_o
);

    localparam int CNT_W = $clog2(WIDTH_N + 1);

    // Grants of the current vector that have not been handed out yet.
    logic [WIDTH_N-1:0] r_pend;
    // Sticky: some accepted vector carried more grants than the arbiter may issue.
    logic               r_err;

    logic [WIDTH_N-1:0] w_onehot;
    logic [WIDTH_N-1:0] w_rest;
    logic [IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_popcnt;
    logic               w_out_vld;
    logic               w_last;
    logic               w_out_hs;
    logic               w_in_rdy;
    logic               w_in_hs;
    logic               w_too_many;

    // Isolate the lowest pending grant; the remainder tells us if it is the last one.
    assign w_onehot  = r_pend & (~r_pend + WIDTH_N'(1));
    assign w_rest    = r_pend & ~w_onehot;
    assign w_out_vld = |r_pend;
    assign w_last    = w_out_vld && (w_rest == '0);
    assign w_out_hs  = w_out_vld && out_rdy_i;

    // Ready when idle, or when the final grant is leaving on this edge.
    assign w_in_rdy  = (r_pend == '0) || (w_out_hs && w_last);
    assign w_in_hs   = gnt_vld_i && w_in_rdy;

    // Binary index of the one-hot grant; zero when nothing is pending.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH_N; i++) begin
            if (w_onehot[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // Count grants in the incoming vector for the over-subscription check.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH_N; i++) begin
            w_popcnt = w_popcnt + CNT_W'(gnt_i[i]);
        end
    end

    assign w_too_many = (w_popcnt > CNT_W'(AMOUNT_M));

    // Pending set: load a new vector on input handshake (wins over the final
    // clear), otherwise retire the lowest grant on output handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else if (w_in_hs) begin
            r_pend <= gnt_i;
        end else if (w_out_hs) begin
            r_pend <= w_rest;
        end
    end

    // Error flag: set on any accepted over-full vector, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_in_hs && w_too_many) begin
            r_err <= 1'b1;
        end
    end

    assign gnt_rdy_o = w_in_rdy;
    assign idx_o     = w_idx;
    assign onehot_o  = w_onehot;
    assign last_o    = w_last;
    assign out_vld_o = w_out_vld;
    assign err_o     = r_err;

endmodule

// File: tb/tb_mtc_gnt_serializer.sv
// Bench for mtc_gnt_serializer (WIDTH_N=8, AMOUNT_M=3): directed scenarios
// with fixed expectations, then randomized traffic against a queue model.
module tb_mtc_gnt_serializer;

    localparam int N = 8;
    localparam int M = 3;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] gnt_i;
    logic         gnt_vld_i;
    logic         gnt_rdy_o;
    logic [2:0]   idx_o;
    logic [N-1:0] onehot_o;
    logic         last_o;
    logic         out_vld_o;
    logic         out_rdy_i;
    logic         err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: indices still to be emitted, in emission order.
    int exp_q[$];
    bit exp_err;

    mtc_gnt_serializer #(.WIDTH_N(N), .AMOUNT_M(M)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .gnt_i     (gnt_i),
        .gnt_vld_i (gnt_vld_i),
        .gnt_rdy_o (gnt_rdy_o),
        .idx_o     (idx_o),
        .onehot_o  (onehot_o),
        .last_o    (last_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .err_o     (err_o)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {err, vld, last, gnt_rdy, idx, onehot}.
    logic [14:0] act;
    assign act = {err_o, out_vld_o, last_o, gnt_rdy_o, idx_o, onehot_o};

    function automatic logic [14:0] exp_vec(input bit e, input bit v, input bit l,
                                            input bit r, input int i);
        logic [N-1:0] oh;
        oh = v ? (N'(1) << i) : '0;
        return {e, v, l, r, (v ? 3'(i) : 3'd0), oh};
    endfunction

    // Driver tasks
    task automatic drive(input bit vld, input logic [N-1:0] g, input bit rdy);
        gnt_vld_i = vld;
        gnt_i     = g;
        out_rdy_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(0, 0, 0, 1, 0)) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", c, act, exp_vec(0, 0, 0, 1, 0));
            end
            tick();
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_spread();
        int ids[3] = '{1, 4, 7};
        drive(1'b1, 8'b1001_0010, 1'b1);
        settle();
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL spread accept: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(0, 1, k == 2, k == 2, ids[k])) begin
                n_fail++;
                $display("FAIL spread grant%0d: got %h want %h", k, act,
                         exp_vec(0, 1, k == 2, k == 2, ids[k]));
            end
            tick();
        end
        settle();
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL spread drained: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ids[3] = '{0, 7, 1};
        bit lst[3] = '{0, 1, 1};
        bit rdy[3] = '{0, 1, 1};
        drive(1'b1, 8'h81, 1'b1);
        tick();
        // Next vector is presented immediately and held until taken.
        drive(1'b1, 8'h02, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(0, 1, lst[k], rdy[k], ids[k])) begin
                n_fail++;
                $display("FAIL b2b grant%0d: got %h want %h", k, act,
                         exp_vec(0, 1, lst[k], rdy[k], ids[k]));
            end
            tick();
            if (k == 1) drive(1'b0, '0, 1'b1);
        end
        settle();
        n_checks++;
        if (out_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b drained: got vld %b want 0", out_vld_o);
        end
        tick();
    endtask

    task automatic test_top_bit();
        drive(1'b1, 8'h80, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        settle();
        n_checks++;
        if (act !== exp_vec(0, 1, 1, 1, 7)) begin
            n_fail++;
            $display("FAIL top_bit: got %h want %h", act, exp_vec(0, 1, 1, 1, 7));
        end
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'h0C, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(0, 1, 0, 0, 2)) begin
                n_fail++;
                $display("FAIL bp hold%0d: got %h want %h", c, act, exp_vec(0, 1, 0, 0, 2));
            end
            tick();
        end
        out_rdy_i = 1'b1;
        settle();
        n_checks++;
        if (act !== exp_vec(0, 1, 0, 0, 2)) begin
            n_fail++;
            $display("FAIL bp release idx2: got %h want %h", act, exp_vec(0, 1, 0, 0, 2));
        end
        tick();
        settle();
        n_checks++;
        if (act !== exp_vec(0, 1, 1, 1, 3)) begin
            n_fail++;
            $display("FAIL bp idx3: got %h want %h", act, exp_vec(0, 1, 1, 1, 3));
        end
        tick();
    endtask

    task automatic test_error();
        drive(1'b1, 8'hFF, 1'b1);
        settle();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err before: got %b want 0", err_o);
        end
        tick();
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(1, 1, k == 7, k == 7, k)) begin
                n_fail++;
                $display("FAIL err grant%0d: got %h want %h", k, act,
                         exp_vec(1, 1, k == 7, k == 7, k));
            end
            tick();
        end
        drive(1'b1, 8'h05, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            settle();
            n_checks++;
            if (act !== exp_vec(1, 1, k == 1, k == 1, 2 * k)) begin
                n_fail++;
                $display("FAIL err sticky%0d: got %h want %h", k, act,
                         exp_vec(1, 1, k == 1, k == 1, 2 * k));
            end
            tick();
        end
        reset_n = 1'b0;
        settle();
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL err cleared: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_and_reset();
        drive(1'b1, 8'h00, 1'b1);
        settle();
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL zero accept: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
        drive(1'b0, '0, 1'b1);
        settle();
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL zero after: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
        drive(1'b1, 8'h70, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        settle();
        n_checks++;
        if (act !== exp_vec(0, 1, 0, 0, 4)) begin
            n_fail++;
            $display("FAIL mid first: got %h want %h", act, exp_vec(0, 1, 0, 0, 4));
        end
        tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (act !== exp_vec(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL mid reset: got %h want %h", act, exp_vec(0, 0, 0, 1, 0));
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++;
            if (out_vld_o !== 1'b0) begin
                n_fail++;
                $display("FAIL mid discard%0d: got vld %b want 0", c, out_vld_o);
            end
            tick();
        end
    endtask

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v;
        int k;
        k = $urandom_range(0, 9);
        v = '0;
        if (k == 9) begin
            v = N'($urandom());
        end else if (k != 0) begin
            for (int j = 0; j < $urandom_range(1, M); j++) v[$urandom_range(0, N - 1)] = 1'b1;
        end
        return v;
    endfunction

    task automatic test_random();
        bit hold;
        bit ohs, ihs, ev, el, er;
        int sz, ei;
        logic [N-1:0] g;
        reset_pulse();
        hold = 1'b0;
        g = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                g = rand_vec();
                drive($urandom_range(0, 2) != 0, g, $urandom_range(0, 3) != 0);
            end else begin
                out_rdy_i = ($urandom_range(0, 3) != 0);
            end
            settle();
            sz = exp_q.size();
            ev = (sz > 0);
            el = (sz == 1);
            er = (sz == 0) || (out_rdy_i && sz == 1);
            ei = ev ? exp_q[0] : 0;
            n_checks++;
            if (act !== exp_vec(exp_err, ev, el, er, ei)) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", c, act,
                         exp_vec(exp_err, ev, el, er, ei));
            end
            ohs = ev && out_rdy_i;
            ihs = gnt_vld_i && er;
            hold = gnt_vld_i && !ihs;
            tick();
            if (ohs) void'(exp_q.pop_front());
            if (ihs) begin
                exp_q.delete();
                for (int i = 0; i < N; i++) if (g[i]) exp_q.push_back(i);
                if ($countones(g) > M) exp_err = 1'b1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        exp_err = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        test_reset();
        test_spread();
        test_back_to_back();
        test_top_bit();
        test_backpressure();
        test_error();
        test_zero_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
